// File: rtl/sync_down_cntr.sv
// ============================================================================
// Module      : sync_down_cntr
// Description : Synchronous loadable down-counter/timer with a start/busy/done
//               handshake.
//               Optional auto-reload: define SYNC_DOWN_CNTR_AUTO_RELOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_down_cntr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_term = 2'd2;

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;

`ifdef SYNC_DOWN_CNTR_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
`ifdef SYNC_DOWN_CNTR_AUTO_RELOAD_EN
        w_reload_nxt = r_reload;
`endif
        case (r_state)
            c_idle: begin
                if (start) begin
                    if (load_val != c_zero) begin
                        w_q_nxt     = load_val;
                        w_state_nxt = c_run;
`ifdef SYNC_DOWN_CNTR_AUTO_RELOAD_EN
                        w_reload_nxt = load_val;
`endif
                    end else begin
                        w_q_nxt     = c_zero;
                        w_state_nxt = c_term;
                    end
                end
            end
            c_run: begin
                if (stop) begin
                    w_q_nxt     = c_zero;
                    w_state_nxt = c_idle;
                end else if (en) begin
                    // Terminal step is taken at 1 so q never underflows.
                    if (r_q <= c_one) begin
                        w_q_nxt     = c_zero;
                        w_state_nxt = c_term;
                    end else begin
                        w_q_nxt = r_q - c_one;
                    end
                end
            end
            c_term: begin
                if (stop) begin
                    w_q_nxt     = c_zero;
                    w_state_nxt = c_idle;
                end else begin
`ifdef SYNC_DOWN_CNTR_AUTO_RELOAD_EN
                    if (start && (load_val != c_zero)) begin
                        w_q_nxt      = load_val;
                        w_reload_nxt = load_val;
                        w_state_nxt  = c_run;
                    end else if (r_reload != c_zero) begin
                        w_q_nxt     = r_reload;
                        w_state_nxt = c_run;
                    end
`else
                    w_state_nxt = c_idle;
`endif
                end
            end
            default: begin
                w_q_nxt     = c_zero;
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= c_idle;
            r_q     <= c_zero;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
        end
    end

`ifdef SYNC_DOWN_CNTR_AUTO_RELOAD_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            r_reload <= c_zero;
        end else begin
            r_reload <= w_reload_nxt;
        end
    end
`endif

    assign q    = r_q;
    assign busy = (r_state != c_idle);
    assign done = (r_state == c_term);

endmodule

`default_nettype wire

// File: tb/tb_sync_down_cntr.sv
// ============================================================================
// Module      : tb_sync_down_cntr
// Description : Self-checking bench for sync_down_cntr: directed scenarios
//               plus random stimulus against a behavioural timer model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_down_cntr;

    localparam int WIDTH = 4;

    logic             clk;
    logic             clear;
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             stop;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    // Behavioural view: a remaining count, an active flag and a done flag.
    int m_q      = 0;
    bit m_busy   = 0;
    bit m_done   = 0;
    int m_reload = 0;

    sync_down_cntr #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .clear    (clear),
        .start    (start),
        .load_val (load_val),
        .en       (en),
        .stop     (stop),
        .q        (q),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit c, input bit s, input int lv, input bit e, input bit sp);
        if (c) begin
            m_q = 0; m_busy = 0; m_done = 0; m_reload = 0;
        end else if (!m_busy) begin
            if (s) begin
                m_busy = 1;
                m_q    = lv;
                m_done = (lv == 0);
                if (lv != 0) m_reload = lv;
            end
        end else if (sp) begin
            m_q = 0; m_busy = 0; m_done = 0;
        end else if (m_done) begin
`ifdef SYNC_DOWN_CNTR_AUTO_RELOAD_EN
            if (s && lv != 0) begin
                m_reload = lv; m_q = lv; m_done = 0;
            end else if (m_reload != 0) begin
                m_q = m_reload; m_done = 0;
            end
`else
            m_busy = 0; m_done = 0;
`endif
        end else if (e) begin
            m_q = (m_q > 0) ? m_q - 1 : 0;
            if (m_q == 0) m_done = 1;
        end
    endtask

    task automatic cyc(input bit c, input bit s, input int lv, input bit e, input bit sp);
        clear    = c;
        start    = s;
        load_val = lv[WIDTH-1:0];
        en       = e;
        stop     = sp;
        @(posedge clk);
        model_edge(c, s, lv, e, sp);
        #1;
        chk("q", 32'(q), 32'(m_q));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
    endtask

    initial begin
        int exp_q [6];
        clear = 1'b1; start = 1'b1; load_val = 4'd7; en = 1'b1; stop = 1'b0;

        // Reset with start held high
        cyc(1, 1, 7, 1, 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_busy", 32'(busy), 0);
        cyc(1, 1, 7, 1, 0);
        chk("rst_done", 32'(done), 0);
        cyc(0, 0, 7, 1, 0);
        chk("rst_idle_busy", 32'(busy), 0);

`ifndef SYNC_DOWN_CNTR_AUTO_RELOAD_EN
        // One-shot count of 5
        exp_q = '{5, 4, 3, 2, 1, 0};
        cyc(0, 1, 5, 1, 0);
        chk("os_q0", 32'(q), 32'(exp_q[0]));
        chk("os_busy0", 32'(busy), 1);
        for (int i = 1; i < 6; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk("os_q", 32'(q), 32'(exp_q[i]));
            chk("os_done", 32'(done), (i == 5) ? 1 : 0);
        end
        cyc(0, 0, 0, 1, 0);
        chk("os_busy_end", 32'(busy), 0);
        chk("os_done_end", 32'(done), 0);

        // Enable gaps
        exp_q = '{3, 2, 2, 1, 1, 0};
        cyc(0, 1, 3, 0, 0);
        chk("gap_q0", 32'(q), 32'(exp_q[0]));
        for (int i = 1; i < 6; i++) begin
            cyc(0, 0, 0, (i % 2), 0);
            chk("gap_q", 32'(q), 32'(exp_q[i]));
        end
        chk("gap_done", 32'(done), 1);
        cyc(0, 0, 0, 0, 0);

        // Zero load
        cyc(0, 1, 0, 0, 0);
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 1);
        cyc(0, 0, 0, 1, 0);
        chk("zero_done_end", 32'(done), 0);
        chk("zero_busy_end", 32'(busy), 0);

        // Abort at q=4
        cyc(0, 1, 9, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
        chk("abort_pre_q", 32'(q), 4);
        cyc(0, 0, 0, 1, 1);
        chk("abort_q", 32'(q), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);

        // Ignored restart, then saturation in IDLE
        cyc(0, 1, 8, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 2, 0, 0);
        chk("restart_q", 32'(q), 6);
        cyc(0, 1, 2, 1, 0);
        chk("restart_q_dec", 32'(q), 5);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        chk("sat_q", 32'(q), 0);
        chk("sat_busy", 32'(busy), 0);
`else
        // Auto-reload period of 3
        exp_q = '{2, 1, 0, 2, 1, 0};
        cyc(0, 1, 2, 1, 0);
        chk("ar_q0", 32'(q), 32'(exp_q[0]));
        for (int i = 1; i < 6; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk("ar_q", 32'(q), 32'(exp_q[i]));
            chk("ar_done", 32'(done), (exp_q[i] == 0) ? 1 : 0);
        end
        cyc(0, 0, 0, 1, 1);
        chk("ar_stop_busy", 32'(busy), 0);
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 31) == 0),
                ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, (1 << WIDTH) - 1)),
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
